uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter with an input FIFO and valid/ready byte interface. It supports configurable bit period, data width, parity mode and stop-bit count, and produces back-to-back frames with no idle gap while data is queued. It sits between any byte-producing logic in the tx_clk domain and the serial pin `tx_output`, and is the general-purpose successor to the fixed 8N1 free-running transmitter.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: tx_clk cycles per bit (434 = 50 MHz / 115200). Legal range is 2 or more.
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries in the input FIFO. Must be a power of two, 2 or more.

Ports:
- `tx_clk`  in  1  clock.
- `tx_rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `tx_data_in`  in  DATA_BITS  byte to send, LSB transmitted first.
- `tx_valid`  in  1  `tx_data_in` is valid.
- `tx_ready`  out  1  FIFO can accept a word. Combinational: `tx_rst_n && !full`.
- `tx_output`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  FSM is not in IDLE. Registered.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of words queued, not counting the word in flight.

## Operation
- **Push:** a word is written on a rising edge where `tx_valid && tx_ready`. `tx_data_in` is ignored otherwise.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx_output` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx_output` = 0 for one bit period, then go to DATA.
  - DATA: shift out the LSB each bit period. After DATA_BITS bits, go to PARITY if `PARITY != 0`, else go to STOP.
  - PARITY: one bit period. The bit is `~^data` when odd, `^data` when even, computed over the popped word.
  - STOP: `tx_output` = 1 for `STOP_BITS*CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle). Otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. The state advances when count == CLKS_PER_BIT-1. A separate bit index counts DATA bits and stop bits.
- **Frame length:** `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT` cycles exactly. Default 8N1 is 4340 cycles.
- **FIFO:** pointers wrap modulo FIFO_DEPTH. Push and pop may occur on the same edge; `fifo_level` is then unchanged. No push is accepted while full, even if a pop occurs on the same edge. Pop occurs only when non-empty.
- **Latching:** the popped word is held in the shift register, so later FIFO writes never alter the frame in flight.
- **Reset:** when `tx_rst_n` is sampled low, on that edge:
  - state = IDLE, `tx_output` = 1, `tx_busy` = 0;
  - FIFO emptied (`fifo_level` = 0), counters = 0;
  - any frame in progress is abandoned, and the line returns high on that edge.

## Timing
- Push accepted at edge k with the FSM in IDLE and the FIFO empty:
  - edge k: `fifo_level` = 1;
  - edge k+1: pop, `fifo_level` = 0, state = START, `tx_output` = 0, `tx_busy` = 1.
  - The start bit therefore appears one cycle after acceptance.
- `tx_output` transitions only on edges where the baud counter wraps or on state entry from IDLE/reset, so there are no glitches.
- Back-to-back frames: the next start bit's falling edge follows the last stop bit with no gap.
- `tx_busy` falls on the edge the FSM enters IDLE.
- `tx_ready` is 0 throughout reset and 1 from the first cycle after reset is released.

## Test plan
- **8N1, CLKS_PER_BIT=434, push 8'h54:** line reads low for 434 cycles, then bits 0,0,1,0,1,0,1,0 at 434 cycles each, then high. `tx_busy` is high for exactly 4340 cycles.
- **PARITY=2 (even), push 8'h54 (three ones):** parity bit = 1. With PARITY=1 (odd), parity bit = 0. Frame length is 4774 cycles.
- **FIFO_DEPTH=4, `tx_valid` held high from edge k with 0x51,0x52,0x53,0x54,0x55,0x56:**
  - five words are accepted (first popped at k+1);
  - `tx_ready` goes low after edge k+4 and the sixth word stalls until the first frame ends;
  - the line shows contiguous frames "QRSTUV" with no idle cycles.
- **DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=4, push 5'h15:** line sequence is 0 (4 cycles), 1,0,1,0,1 (4 cycles each), then 1 for 8 cycles. Total 32 cycles.
- **Reset mid-frame:** assert `tx_rst_n`=0 during bit D3 with 2 words queued. On the next edge `tx_output`=1, `fifo_level`=0 and `tx_busy`=0. After release, the line stays high with no residual frame.
- **Same-edge push and pop:** with `fifo_level`=2 at end of STOP, push a word on the pop edge. `fifo_level` stays 2 and the popped data is the FIFO head.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: input FIFO with valid/ready push side, and a
// frame FSM that serialises start, data (LSB first), optional parity and stop bits.
module uart_tx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               tx_clk,
  input  logic                               tx_rst_n,
  input  logic [DATA_BITS-1:0]               tx_data_in,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx_output,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 baud_done;

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign tx_ready   = tx_rst_n && !full;
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~^head : ^head;
  assign fifo_level = level_q;
  assign tx_output  = line_q;
  assign tx_busy    = busy_q;
  assign baud_done  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Storage array carries no reset; only pointers and level define contents.
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; the line value is computed one cycle ahead so it changes only on bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_done ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = line_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        line_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          bit_d   = '0;
          line_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          bit_d   = '0;
          line_d  = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              line_d  = par_q;
              state_d = S_PARITY;
            end else begin
              line_d  = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          bit_d   = '0;
          line_d  = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = head_par;
              line_d  = 1'b0;
              state_d = S_START;
            end else begin
              line_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances cover 8N1, even/odd parity,
// 5-bit/2-stop, and FIFO back-to-back, same-edge push/pop and mid-frame reset.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic       rst, rst4;
  logic [7:0] d0, d1, d2, d4;
  logic [4:0] d3;
  logic       v0, v1, v2, v3, v4;
  logic       ready0, ready1, ready2, ready3, ready4;
  logic       line0, line1, line2, line3, line4;
  logic       busy0, busy1, busy2, busy3, busy4;
  logic [2:0] lvl0, lvl1, lvl2, lvl3, lvl4;

  int         sel;
  logic       obs_line, obs_busy;
  logic [63:0] cap_bits;
  int          cap_cyc;
  logic [63:0] exp_bits;
  int          stall;
  int          lows;

  uart_tx_cfg u0 (
    .tx_clk(clk), .tx_rst_n(rst), .tx_data_in(d0), .tx_valid(v0), .tx_ready(ready0),
    .tx_output(line0), .tx_busy(busy0), .fifo_level(lvl0)
  );
  uart_tx_cfg #(.PARITY(2)) u1 (
    .tx_clk(clk), .tx_rst_n(rst), .tx_data_in(d1), .tx_valid(v1), .tx_ready(ready1),
    .tx_output(line1), .tx_busy(busy1), .fifo_level(lvl1)
  );
  uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY(1)) u2 (
    .tx_clk(clk), .tx_rst_n(rst), .tx_data_in(d2), .tx_valid(v2), .tx_ready(ready2),
    .tx_output(line2), .tx_busy(busy2), .fifo_level(lvl2)
  );
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u3 (
    .tx_clk(clk), .tx_rst_n(rst), .tx_data_in(d3), .tx_valid(v3), .tx_ready(ready3),
    .tx_output(line3), .tx_busy(busy3), .fifo_level(lvl3)
  );
  uart_tx_cfg #(.CLKS_PER_BIT(4)) u4 (
    .tx_clk(clk), .tx_rst_n(rst4), .tx_data_in(d4), .tx_valid(v4), .tx_ready(ready4),
    .tx_output(line4), .tx_busy(busy4), .fifo_level(lvl4)
  );

  always_comb begin
    obs_line = line4;
    obs_busy = busy4;
    case (sel)
      0: begin obs_line = line0; obs_busy = busy0; end
      1: begin obs_line = line1; obs_busy = busy1; end
      2: begin obs_line = line2; obs_busy = busy2; end
      3: begin obs_line = line3; obs_busy = busy3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after the start-bit edge: samples each bit at its centre and counts busy cycles.
  task automatic run_frame(input int cpb, input int limit, output logic [63:0] bits, output int cyc);
    int t = 0;
    bits = '0;
    while (obs_busy && t < limit) begin
      if ((t % cpb) == (cpb / 2) && (t / cpb) < 64) bits[t / cpb] = obs_line;
      t++;
      tick(1);
    end
    cyc = t;
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0; sel = 0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; v4 = 1'b0;
    tick(2);
    check("rst_ready", {59'd0, ready0, ready1, ready2, ready3, ready4}, 64'd0);
    check("rst_line", {59'd0, line0, line1, line2, line3, line4}, 64'h1f);
    check("rst_busy", {59'd0, busy0, busy1, busy2, busy3, busy4}, 64'd0);
    check("rst_lvl", {52'd0, lvl0, lvl1, lvl4}, 64'd0);
    rst = 1'b1; rst4 = 1'b1;
    tick(1);
    check("post_rst_ready", {59'd0, ready0, ready1, ready2, ready3, ready4}, 64'h1f);

    // 8N1 at 434 clocks per bit
    sel = 0; d0 = 8'h54; v0 = 1'b1;
    tick(1);
    check("u0_lvl_push", 64'(lvl0), 64'd1);
    check("u0_line_idle", 64'(line0), 64'd1);
    v0 = 1'b0;
    tick(1);
    check("u0_start_busy", 64'(busy0), 64'd1);
    check("u0_start_line", 64'(line0), 64'd0);
    check("u0_lvl_pop", 64'(lvl0), 64'd0);
    run_frame(434, 6000, cap_bits, cap_cyc);
    check("u0_bits", cap_bits, 64'h2a8);
    check("u0_busy_len", 64'(cap_cyc), 64'd4340);
    check("u0_line_after", 64'(line0), 64'd1);

    // even parity, 434 clocks per bit
    sel = 1; d1 = 8'h54; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(1);
    run_frame(434, 6000, cap_bits, cap_cyc);
    check("u1_bits", cap_bits, 64'h6a8);
    check("u1_busy_len", 64'(cap_cyc), 64'd4774);

    // odd parity, 4 clocks per bit
    sel = 2; d2 = 8'h54; v2 = 1'b1;
    tick(1);
    v2 = 1'b0;
    tick(1);
    run_frame(4, 200, cap_bits, cap_cyc);
    check("u2_bits", cap_bits, 64'h4a8);
    check("u2_busy_len", 64'(cap_cyc), 64'd44);

    // 5 data bits, 2 stop bits
    sel = 3; d3 = 5'h15; v3 = 1'b1;
    tick(1);
    v3 = 1'b0;
    tick(1);
    run_frame(4, 200, cap_bits, cap_cyc);
    check("u3_bits", cap_bits, 64'hea);
    check("u3_busy_len", 64'(cap_cyc), 64'd32);

    // FIFO fill with valid held high: QRSTUV back to back
    sel = 4; d4 = 8'h51; v4 = 1'b1;
    tick(1);
    check("u4_lvl_k", 64'(lvl4), 64'd1);
    d4 = 8'h52;
    tick(1);
    check("u4_lvl_k1", 64'(lvl4), 64'd1);
    check("u4_busy_k1", 64'(busy4), 64'd1);
    fork
      run_frame(4, 400, cap_bits, cap_cyc);
      begin
        d4 = 8'h53; tick(1);
        d4 = 8'h54; tick(1);
        d4 = 8'h55; tick(1);
        check("u4_ready_full", 64'(ready4), 64'd0);
        check("u4_lvl_full", 64'(lvl4), 64'd4);
        d4 = 8'h56;
        stall = 0;
        while (!ready4 && stall < 100) begin
          stall++;
          tick(1);
        end
        check("u4_stall", 64'(stall), 64'd37);
        tick(1);
        v4 = 1'b0;
      end
    join
    exp_bits = '0;
    for (int i = 0; i < 6; i++) exp_bits |= (64'h200 | (64'(8'h51 + i) << 1)) << (10 * i);
    check("u4_qrstuv", cap_bits, exp_bits);
    check("u4_qrstuv_len", 64'(cap_cyc), 64'd240);

    // same-edge push and pop with two words queued at end of STOP
    d4 = 8'h61; v4 = 1'b1;
    tick(1);
    d4 = 8'h62;
    tick(1);
    fork
      run_frame(4, 400, cap_bits, cap_cyc);
      begin
        d4 = 8'h63; tick(1);
        v4 = 1'b0;
        check("u4_lvl_two", 64'(lvl4), 64'd2);
        tick(38);
        d4 = 8'h64; v4 = 1'b1;
        tick(1);
        v4 = 1'b0;
        check("u4_lvl_same_edge", 64'(lvl4), 64'd2);
      end
    join
    exp_bits = '0;
    for (int i = 0; i < 4; i++) exp_bits |= (64'h200 | (64'(8'h61 + i) << 1)) << (10 * i);
    check("u4_same_edge_data", cap_bits, exp_bits);

    // reset during D3 with two words queued
    d4 = 8'h71; v4 = 1'b1;
    tick(1);
    d4 = 8'h72; tick(1);
    d4 = 8'h73; tick(1);
    v4 = 1'b0;
    tick(16);
    check("u4_pre_rst_lvl", 64'(lvl4), 64'd2);
    check("u4_pre_rst_busy", 64'(busy4), 64'd1);
    rst4 = 1'b0;
    #1;
    check("u4_rst_ready", 64'(ready4), 64'd0);
    tick(1);
    check("u4_rst_line", 64'(line4), 64'd1);
    check("u4_rst_lvl", 64'(lvl4), 64'd0);
    check("u4_rst_busy", 64'(busy4), 64'd0);
    rst4 = 1'b1;
    tick(1);
    check("u4_rel_ready", 64'(ready4), 64'd1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (!line4 || busy4) lows++;
      tick(1);
    end
    check("u4_no_residual", 64'(lows), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
